mdu_unit: RTL and testbench

- Multiply/divide unit in the EX stage.
- Executes the HI/LO commands that the decode controller issues through its start strobe and 4-bit operation type.
- Models multi-cycle latency with a busy counter, so the hazard logic can stall any following HI/LO instruction.
- Supplies the HI/LO value for mfhi/mflo writeback.

---
 rtl/mdu_unit_if.sv | 22 ++
 rtl/mdu_unit.sv | 169 ++++++++++++++++
 tb/tb_mdu_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
// Command/result bundle between the decode controller and the EX-stage multiply/divide unit.
interface mdu_unit_if;
    logic        start;
    logic [3:0]  mdu_type;
    logic        flush;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_out;

    modport master (
        output start, mdu_type, flush, src_a, src_b,
        input  busy, hi, lo, mf_out
    );

    modport slave (
        input  start, mdu_type, flush, src_a, src_b,
        output busy, hi, lo, mf_out
    );
endinterface

// File: rtl/mdu_unit.sv
// HI/LO multiply/divide unit with a busy counter that models multi-cycle latency.
// Optional MADD (type 9) is enabled by defining MDU_MADD_EN.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset_n,
    mdu_unit_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] T_MULT  = 4'd1;
    localparam logic [3:0] T_MULTU = 4'd2;
    localparam logic [3:0] T_DIV   = 4'd3;
    localparam logic [3:0] T_DIVU  = 4'd4;
    localparam logic [3:0] T_MFLO  = 4'd6;
    localparam logic [3:0] T_MTHI  = 4'd7;
    localparam logic [3:0] T_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] T_MADD  = 4'd9;
`endif
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [3:0]  count;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] ph;
    logic [31:0] pl;
    logic        pvalid;

    logic        accept;
    logic        launch;
    logic        done;
    logic [3:0]  launch_cnt;
    logic [63:0] launch_result;
    logic        launch_valid;

    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    // One shared magnitude divider; signs are reapplied so the quotient truncates toward zero.
    always_comb begin
        prod_signed   = {{32{bus.src_a[31]}}, bus.src_a} * {{32{bus.src_b[31]}}, bus.src_b};
        prod_unsigned = {32'd0, bus.src_a} * {32'd0, bus.src_b};
        a_neg    = (bus.mdu_type == T_DIV) & bus.src_a[31];
        b_neg    = (bus.mdu_type == T_DIV) & bus.src_b[31];
        div_zero = (bus.src_b == 32'd0);
        div_n    = a_neg ? (~bus.src_a + 32'd1) : bus.src_a;
        div_d    = b_neg ? (~bus.src_b + 32'd1) : bus.src_b;
        if (div_zero) begin
            div_d = 32'd1;
        end
        uq   = div_n / div_d;
        ur   = div_n % div_d;
        quot = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem  = a_neg ? (~ur + 32'd1) : ur;
    end

    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        launch        = 1'b0;
        done          = 1'b0;
        launch_cnt    = 4'd0;
        launch_result = 64'd0;
        launch_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept = 1'b1;
                    case (bus.mdu_type)
                        T_MULT: begin
                            launch        = 1'b1;
                            launch_cnt    = MULT_CNT;
                            launch_result = prod_signed;
                            launch_valid  = 1'b1;
                        end
                        T_MULTU: begin
                            launch        = 1'b1;
                            launch_cnt    = MULT_CNT;
                            launch_result = prod_unsigned;
                            launch_valid  = 1'b1;
                        end
                        T_DIV, T_DIVU: begin
                            launch        = 1'b1;
                            launch_cnt    = DIV_CNT;
                            launch_result = {rem, quot};
                            launch_valid  = !div_zero;
                        end
`ifdef MDU_MADD_EN
                        T_MADD: begin
                            launch        = 1'b1;
                            launch_cnt    = MULT_CNT;
                            launch_result = {hi_q, lo_q} + prod_signed;
                            launch_valid  = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                    if (launch) begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (count == 4'd1) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= 4'd0;
            ph     <= 32'd0;
            pl     <= 32'd0;
            pvalid <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            state <= next_state;
            if (launch) begin
                count  <= launch_cnt;
                ph     <= launch_result[63:32];
                pl     <= launch_result[31:0];
                pvalid <= launch_valid;
            end else if (done) begin
                count  <= 4'd0;
                pvalid <= 1'b0;
                if (pvalid) begin
                    hi_q <= ph;
                    lo_q <= pl;
                end
            end else if (state == RUN) begin
                count <= count - 4'd1;
            end
            if (accept && bus.mdu_type == T_MTHI) begin
                hi_q <= bus.src_a;
            end
            if (accept && bus.mdu_type == T_MTLO) begin
                lo_q <= bus.src_a;
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.mf_out = (bus.mdu_type == T_MFLO) ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed testbench for mdu_unit; MADD expectations follow MDU_MADD_EN.
module tb_mdu_unit;

    localparam logic [3:0] T_NONE  = 4'd0;
    localparam logic [3:0] T_MULT  = 4'd1;
    localparam logic [3:0] T_MULTU = 4'd2;
    localparam logic [3:0] T_DIV   = 4'd3;
    localparam logic [3:0] T_DIVU  = 4'd4;
    localparam logic [3:0] T_MFHI  = 4'd5;
    localparam logic [3:0] T_MFLO  = 4'd6;
    localparam logic [3:0] T_MTHI  = 4'd7;
    localparam logic [3:0] T_MTLO  = 4'd8;
    localparam logic [3:0] T_MADD  = 4'd9;

    logic clk;
    logic reset_n;
    int   tests;
    int   failed;
    int   cnt;

    mdu_unit_if bus ();

    mdu_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle command at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.mdu_type = t;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.flush    = fl;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.mdu_type = T_NONE;
        bus.flush    = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failed++;
            $display("[TB] FAIL reset_state: busy=%b hi=%h lo=%h, expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        reset_n = 1'b1;
        issue(T_MTHI, 32'h0000_AAAA, 32'd0, 1'b0);
        issue(T_MULT, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failed++;
            $display("[TB] FAIL reset_mid_mult: busy=%b hi=%h lo=%h, expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.lo !== 32'd0 || bus.hi !== 32'd0) begin
            failed++;
            $display("[TB] FAIL reset_no_commit: busy=%b hi=%h lo=%h, expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult;
        issue(T_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_idle(cnt);
        tests++;
        if (cnt !== 5) begin
            failed++;
            $display("[TB] FAIL mult_latency: got %0d cycles, expected 5", cnt);
        end
        tests++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
            failed++;
            $display("[TB] FAIL mult_result: hi=%h lo=%h, expected ffffffff/fffffffe", bus.hi, bus.lo);
        end
        issue(T_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        tests++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.busy !== 1'b1) begin
            failed++;
            $display("[TB] FAIL multu_hold: hi=%h busy=%b, expected ffffffff/1", bus.hi, bus.busy);
        end
        wait_idle(cnt);
        tests++;
        if (cnt !== 5 || bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE) begin
            failed++;
            $display("[TB] FAIL multu_result: cycles=%0d hi=%h lo=%h, expected 5/00000001/fffffffe",
                     cnt, bus.hi, bus.lo);
        end
    endtask

    task automatic test_div;
        issue(T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(cnt);
        tests++;
        if (cnt !== 10 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            failed++;
            $display("[TB] FAIL div_neg7_2: cycles=%0d hi=%h lo=%h, expected 10/ffffffff/fffffffd",
                     cnt, bus.hi, bus.lo);
        end
        issue(T_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
        wait_idle(cnt);
        tests++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'd1) begin
            failed++;
            $display("[TB] FAIL div_7_neg2: hi=%h lo=%h, expected 00000001/fffffffd", bus.hi, bus.lo);
        end
        issue(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(cnt);
        tests++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            failed++;
            $display("[TB] FAIL div_overflow: hi=%h lo=%h, expected 00000000/80000000", bus.hi, bus.lo);
        end
        issue(T_DIVU, 32'd7, 32'd0, 1'b0);
        wait_idle(cnt);
        tests++;
        if (cnt !== 10 || bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            failed++;
            $display("[TB] FAIL divu_by_zero: cycles=%0d hi=%h lo=%h, expected 10/00000000/80000000",
                     cnt, bus.hi, bus.lo);
        end
        issue(T_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b0);
        wait_idle(cnt);
        tests++;
        if (bus.lo !== 32'h0FFF_FFFF || bus.hi !== 32'd15) begin
            failed++;
            $display("[TB] FAIL divu_result: hi=%h lo=%h, expected 0000000f/0fffffff", bus.hi, bus.lo);
        end
    endtask

    task automatic test_move;
        issue(T_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        tests++;
        if (bus.hi !== 32'h0000_1234 || bus.busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL mthi: hi=%h busy=%b, expected 00001234/0", bus.hi, bus.busy);
        end
        issue(T_MTLO, 32'h0000_5678, 32'd0, 1'b0);
        bus.mdu_type = T_MFHI;
        #1;
        tests++;
        if (bus.mf_out !== 32'h0000_1234) begin
            failed++;
            $display("[TB] FAIL mfhi_out: got %h expected 00001234", bus.mf_out);
        end
        bus.mdu_type = T_MFLO;
        #1;
        tests++;
        if (bus.mf_out !== 32'h0000_5678) begin
            failed++;
            $display("[TB] FAIL mflo_out: got %h expected 00005678", bus.mf_out);
        end
        issue(T_MFHI, 32'hDEAD_BEEF, 32'd1, 1'b0);
        issue(T_MFLO, 32'hDEAD_BEEF, 32'd1, 1'b0);
        issue(4'd10, 32'hDEAD_BEEF, 32'd1, 1'b0);
        tests++;
        if (bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0000_5678 || bus.busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL noop_types: hi=%h lo=%h busy=%b, expected 00001234/00005678/0",
                     bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_flush;
        issue(T_MULT, 32'd5, 32'd5, 1'b1);
        tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0000_5678) begin
            failed++;
            $display("[TB] FAIL flush_start: busy=%b hi=%h lo=%h, expected 0/00001234/00005678",
                     bus.busy, bus.hi, bus.lo);
        end
        issue(T_MULT, 32'd6, 32'd7, 1'b0);
        bus.flush = 1'b1;
        wait_idle(cnt);
        bus.flush = 1'b0;
        tests++;
        if (cnt !== 5 || bus.lo !== 32'd42 || bus.hi !== 32'd0) begin
            failed++;
            $display("[TB] FAIL flush_in_flight: cycles=%0d hi=%h lo=%h, expected 5/00000000/0000002a",
                     cnt, bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back;
        issue(T_MULT, 32'd3, 32'd4, 1'b0);
        bus.start    = 1'b1;
        bus.mdu_type = T_DIV;
        bus.src_a    = 32'd100;
        bus.src_b    = 32'd3;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.mdu_type = T_NONE;
        wait_idle(cnt);
        tests++;
        if (cnt + 1 !== 5 || bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
            failed++;
            $display("[TB] FAIL start_while_busy: cycles=%0d hi=%h lo=%h, expected 5/00000000/0000000c",
                     cnt + 1, bus.hi, bus.lo);
        end
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.lo !== 32'd12) begin
            failed++;
            $display("[TB] FAIL ignored_div_stays_idle: busy=%b lo=%h, expected 0/0000000c", bus.busy, bus.lo);
        end
    endtask

    task automatic test_madd;
        issue(T_MTHI, 32'd0, 32'd0, 1'b0);
        issue(T_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(T_MADD, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        wait_idle(cnt);
        tests++;
        if (cnt !== 5 || bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
            failed++;
            $display("[TB] FAIL madd: cycles=%0d hi=%h lo=%h, expected 5/00000001/00000000",
                     cnt, bus.hi, bus.lo);
        end
`else
        tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'hFFFF_FFFF) begin
            failed++;
            $display("[TB] FAIL madd_disabled: busy=%b hi=%h lo=%h, expected 0/00000000/ffffffff",
                     bus.busy, bus.hi, bus.lo);
        end
`endif
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.mdu_type = T_NONE;
        bus.flush    = 1'b0;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_flush();
        test_back_to_back();
        test_madd();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
